// File: rtl/test_status_sig_pkg.sv
// Shared constants, state/branch enums and the expected-character lookup
// for the end-of-test signature detector.
package test_status_sig_pkg;

  localparam int SigLen    = 18;
  localparam int BranchIdx = 5;

  localparam logic [7:0] CharLf = 8'h0A;
  localparam logic [7:0] CharCr = 8'h0D;
  localparam logic [7:0] CharP  = 8'h50;
  localparam logic [7:0] CharF  = 8'h46;

  typedef enum logic [1:0] {SOL, MATCH, SKIP, EOL} sig_state_e;
  typedef enum logic {BR_PASS, BR_FAIL} sig_branch_e;

  // "TEST PASSED CHECKS" / "TEST FAILED CHECKS"; returns 0 past the end.
  function automatic logic [7:0] exp_char(input logic [4:0] idx, input sig_branch_e branch);
    logic is_pass;
    logic [7:0] c;
    is_pass = (branch == BR_PASS);
    case (idx)
      5'd0:    c = "T";
      5'd1:    c = "E";
      5'd2:    c = "S";
      5'd3:    c = "T";
      5'd4:    c = " ";
      5'd5:    c = is_pass ? CharP : CharF;
      5'd6:    c = "A";
      5'd7:    c = is_pass ? "S" : "I";
      5'd8:    c = is_pass ? "S" : "L";
      5'd9:    c = "E";
      5'd10:   c = "D";
      5'd11:   c = " ";
      5'd12:   c = "C";
      5'd13:   c = "H";
      5'd14:   c = "E";
      5'd15:   c = "C";
      5'd16:   c = "K";
      5'd17:   c = "S";
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/test_status_sig_detector.sv
// Scans a byte stream for "TEST PASSED CHECKS" / "TEST FAILED CHECKS" lines
// at start of line and keeps the first verdict as sticky status.
//
// state | meaning
// SOL   | at start of line, waiting for 'T'
// MATCH | inside a candidate signature, idx = next expected position
// SKIP  | line cannot match, discard until LF
// EOL   | full signature seen, waiting for LF (optionally one CR first)
module test_status_sig_detector
  import test_status_sig_pkg::*;
#(
  parameter int LineCntW = 16,
  parameter int AcceptCr = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  input  logic [7:0]          in_data_i,
  input  logic                clear_i,
  output logic                sig_pulse_o,
  output logic                status_valid_o,
  output logic                passed_o,
  output logic                failed_o,
  output logic                dup_o,
  output logic [LineCntW-1:0] line_cnt_o
);

  localparam logic [4:0] BranchPos = 5'(BranchIdx);
  localparam logic [4:0] LastIdx   = 5'(SigLen - 1);

  sig_state_e  state;
  sig_branch_e branch;
  logic [4:0]  idx;
  logic        cr_seen;
  logic [7:0]  exp_byte;
  logic        byte_match;
  logic        is_lf;

  assign exp_byte = exp_char(idx, branch);
  assign is_lf    = (in_data_i == CharLf);

  // At the branch position either letter is acceptable; it picks the branch.
  always_comb begin
    byte_match = 1'b0;
    if (idx == BranchPos) byte_match = (in_data_i == CharP) || (in_data_i == CharF);
    else                  byte_match = (in_data_i == exp_byte);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= SOL;
      branch         <= BR_PASS;
      idx            <= 5'd0;
      cr_seen        <= 1'b0;
      sig_pulse_o    <= 1'b0;
      status_valid_o <= 1'b0;
      passed_o       <= 1'b0;
      failed_o       <= 1'b0;
      dup_o          <= 1'b0;
      line_cnt_o     <= '0;
    end else begin
      sig_pulse_o <= 1'b0;
      if (clear_i) begin
        status_valid_o <= 1'b0;
        passed_o       <= 1'b0;
        failed_o       <= 1'b0;
        dup_o          <= 1'b0;
      end
      if (in_valid_i) begin
        if (is_lf && (line_cnt_o != '1)) line_cnt_o <= line_cnt_o + LineCntW'(1);
        case (state)
          SOL: begin
            if (in_data_i == exp_char(5'd0, branch)) begin
              state <= MATCH;
              idx   <= 5'd1;
            end else if (!is_lf) begin
              state <= SKIP;
            end
          end
          MATCH: begin
            if (byte_match) begin
              if (idx == BranchPos) branch <= (in_data_i == CharF) ? BR_FAIL : BR_PASS;
              if (idx == LastIdx) begin
                state   <= EOL;
                cr_seen <= 1'b0;
              end else begin
                idx <= idx + 5'd1;
              end
            end else begin
              state <= is_lf ? SOL : SKIP;
              idx   <= 5'd0;
            end
          end
          SKIP: begin
            if (is_lf) state <= SOL;
          end
          EOL: begin
            idx <= 5'd0;
            if (is_lf) begin
              state       <= SOL;
              sig_pulse_o <= 1'b1;
              // A clear in the same cycle yields to the hit: reload as first verdict.
              if (!status_valid_o || clear_i) begin
                status_valid_o <= 1'b1;
                passed_o       <= (branch == BR_PASS);
                failed_o       <= (branch == BR_FAIL);
                dup_o          <= 1'b0;
              end else begin
                dup_o <= 1'b1;
              end
            end else if ((AcceptCr != 0) && (in_data_i == CharCr) && !cr_seen) begin
              cr_seen <= 1'b1;
            end else begin
              state <= SKIP;
            end
          end
          default: state <= SOL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_test_status_sig_detector.sv
// Scoreboard bench: a line-buffer reference model predicts every cycle's
// outputs, a monitor pops and compares one cycle after each edge.
module tb_test_status_sig_detector;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic [7:0]  in_data_i;
  logic        clear_i;
  logic        sig_pulse_o, status_valid_o, passed_o, failed_o, dup_o;
  logic [15:0] line_cnt_o;

  always #5 clk = ~clk;

  test_status_sig_detector #(.LineCntW(16), .AcceptCr(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .clear_i(clear_i), .sig_pulse_o(sig_pulse_o), .status_valid_o(status_valid_o),
    .passed_o(passed_o), .failed_o(failed_o), .dup_o(dup_o), .line_cnt_o(line_cnt_o)
  );

  typedef struct {
    logic        pulse, sv, pa, fa, dup;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: the text of the current line, and the sticky verdict.
  byte unsigned line_q[$];
  bit   m_sv, m_pa, m_fa, m_dup;
  int   m_cnt;
  string s_pass    = "TEST PASSED CHECKS";
  string s_fail    = "TEST FAILED CHECKS";
  string s_pass_cr = {"TEST PASSED CHECKS", "\r"};
  string s_fail_cr = {"TEST FAILED CHECKS", "\r"};

  function automatic bit line_is(string s);
    if (line_q.size() != s.len()) return 1'b0;
    for (int i = 0; i < s.len(); i++)
      if (line_q[i] != s[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit rstn, input bit v, input logic [7:0] d, input bit clr);
    exp_t e;
    bit   is_pass, is_fail;
    rst_ni     = rstn;
    in_valid_i = v;
    in_data_i  = d;
    clear_i    = clr;
    e.pulse    = 1'b0;
    if (!rstn) begin
      line_q.delete();
      m_sv = 0; m_pa = 0; m_fa = 0; m_dup = 0; m_cnt = 0;
    end else begin
      if (clr) begin m_sv = 0; m_pa = 0; m_fa = 0; m_dup = 0; end
      if (v) begin
        if (d == 8'h0A) begin
          if (m_cnt < 65535) m_cnt++;
          is_pass = line_is(s_pass) || line_is(s_pass_cr);
          is_fail = line_is(s_fail) || line_is(s_fail_cr);
          if (is_pass || is_fail) begin
            e.pulse = 1'b1;
            if (!m_sv) begin m_sv = 1; m_pa = is_pass; m_fa = is_fail; m_dup = 0; end
            else m_dup = 1;
          end
          line_q.delete();
        end else if (line_q.size() < 32) begin
          line_q.push_back(d);
        end
      end
    end
    e.sv = m_sv; e.pa = m_pa; e.fa = m_fa; e.dup = m_dup; e.cnt = m_cnt[15:0];
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00, 0);
  endtask

  // Sends s (optionally with one byte replaced) followed by LF.
  task automatic send_line(input string s, input int bad_idx, input logic [7:0] bad_ch,
                           input bit gaps);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = (i == bad_idx) ? bad_ch : s[i];
      step(1, 1, c, 0);
      if (gaps && ($urandom_range(0, 5) == 0)) idle($urandom_range(1, 2));
    end
    step(1, 1, 8'h0A, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (sig_pulse_o !== e.pulse || status_valid_o !== e.sv || passed_o !== e.pa ||
          failed_o !== e.fa || dup_o !== e.dup || line_cnt_o !== e.cnt) begin
        n_bad++;
        $display("FAIL outputs t=%0t got pulse=%b sv=%b pa=%b fa=%b dup=%b cnt=%0d expected pulse=%b sv=%b pa=%b fa=%b dup=%b cnt=%0d",
                 $time, sig_pulse_o, status_valid_o, passed_o, failed_o, dup_o, line_cnt_o,
                 e.pulse, e.sv, e.pa, e.fa, e.dup, e.cnt);
      end
      n_cmp++;
      if (passed_o && failed_o) begin
        n_bad++;
        $display("FAIL verdict_exclusive t=%0t got passed=%b failed=%b expected not both 1",
                 $time, passed_o, failed_o);
      end
    end
  end

  initial begin
    string s;
    int    kind, n;
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // Directed scenarios
    send_line("TEST PASSED CHECKS", -1, 8'h00, 0);
    idle(2);
    step(1, 0, 8'h00, 1);
    send_line("xx TEST FAILED CHECKS", -1, 8'h00, 0);
    send_line("TEST FAILED CHECK", -1, 8'h00, 0);
    send_line("TEST PASSED CHECKS", -1, 8'h00, 0);
    send_line(s_fail_cr, -1, 8'h00, 0);
    idle(1);
    step(1, 0, 8'h00, 1);
    send_line("TEST PASSED CHECKS!", -1, 8'h00, 0);
    send_line({"TEST FAILED CHECKS", "\r\r"}, -1, 8'h00, 0);
    send_line("TEST PAILED CHECKS", -1, 8'h00, 0);
    send_line("TEST PASSED CHECKS", -1, 8'h00, 0);
    step(1, 0, 8'h00, 1);
    send_line("TEST FAILED CHECKS", -1, 8'h00, 0);
    s = "TEST PAS";
    for (int i = 0; i < s.len(); i++) step(1, 1, s[i], 0);
    step(0, 0, 8'h00, 0);
    send_line("SSED CHECKS", -1, 8'h00, 0);
    send_line("TEST FAILED CHECKS", -1, 8'h00, 0);
    // Hit and clear on the same cycle
    s = "TEST PASSED CHECKS";
    for (int i = 0; i < s.len(); i++) step(1, 1, s[i], 0);
    step(1, 1, 8'h0A, 1);

    // Randomized lines
    for (int l = 0; l < 300; l++) begin
      kind = $urandom_range(0, 8);
      case (kind)
        0: send_line(s_pass, -1, 8'h00, 1);
        1: send_line(s_fail, -1, 8'h00, 1);
        2: send_line(s_pass_cr, -1, 8'h00, 1);
        3: send_line(s_fail_cr, -1, 8'h00, 1);
        4: send_line(($urandom_range(0, 1) != 0) ? s_pass : s_fail, $urandom_range(0, 17),
                     8'($urandom_range(32, 126)), 1);
        5: send_line({" ", s_pass}, -1, 8'h00, 1);
        6: send_line(s_fail.substr(0, $urandom_range(0, 16)), -1, 8'h00, 1);
        7: begin
          n = $urandom_range(0, 24);
          for (int i = 0; i < n; i++)
            step(1, 1, ($urandom_range(0, 3) == 0) ? 8'h54 : 8'($urandom_range(13, 126)), 0);
          step(1, 1, 8'h0A, 0);
        end
        default: begin
          step(1, ($urandom_range(0, 1) != 0), 8'h0A, 1);
          if ($urandom_range(0, 3) == 0) begin
            step(1, 1, 8'h54, 0);
            step(0, 0, 8'h00, 0);
          end
        end
      endcase
    end

    // Line counter saturation, matcher still alive afterwards
    for (int i = 0; i < 65540; i++) step(1, 1, 8'h0A, 0);
    send_line(s_fail, -1, 8'h00, 0);
    send_line(s_pass, -1, 8'h00, 0);
    idle(3);

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
